// File: rtl/argmin_pipe_if.sv
// argmin_pipe_if: cost-vector input and argmin result bundle.
interface argmin_pipe_if #(
    parameter int WIDTH = 32,
    parameter int COUNT = 10,
    parameter int ADDR_WIDTH = 4
);
    logic                   in_valid;
    logic [COUNT*WIDTH-1:0] inp;
    logic                   out_valid;
    logic [WIDTH-1:0]       outp;
    logic [ADDR_WIDTH-1:0]  outp_addr;
    logic [WIDTH-1:0]       outp_second;
    logic                   outp_unique;
    modport master (
        output in_valid, inp,
        input  out_valid, outp, outp_addr, outp_second, outp_unique
    );
    modport slave (
        input  in_valid, inp,
        output out_valid, outp, outp_addr, outp_second, outp_unique
    );
endinterface

// File: rtl/argmin_pipe.sv
// argmin_pipe: registered binary tree returning min cost, its index, runner-up and uniqueness.
module argmin_pipe #(
    parameter int              WIDTH      = 32,
    parameter int              COUNT      = 10,
    parameter int              ADDR_WIDTH = 4,
    parameter bit              TIE_HIGH   = 1'b0,
    parameter logic [WIDTH-1:0] MARGIN    = '0
) (
    input logic          clk,
    input logic          rst,
    argmin_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(COUNT);
    localparam int HALF = (COUNT + 1) / 2;
    typedef struct packed {
        logic [WIDTH-1:0]      mn;
        logic [ADDR_WIDTH-1:0] idx;
        logic [WIDTH-1:0]      sec;
    } node_t;
    node_t             src [COUNT];
    node_t             node_d [LEVELS][HALF];
    node_t             node_q [LEVELS][HALF];
    logic [LEVELS-1:0] vld_d, vld_q;
    logic              uniq_d, uniq_q;

    function automatic logic [WIDTH-1:0] min2(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
        return x < y ? x : y;
    endfunction

    function automatic node_t merge(node_t a, node_t b);
        node_t r;
        logic  b_wins;
        b_wins = TIE_HIGH ? b.mn <= a.mn : b.mn < a.mn;
        r.mn = b_wins ? b.mn : a.mn;
        r.idx = b_wins ? b.idx : a.idx;
        r.sec = min2(b_wins ? a.mn : b.mn, min2(a.sec, b.sec));
        return r;
    endfunction

    // src holds the node list feeding the level being built; an odd last node passes through.
    always_comb begin
        int cnt;
        cnt = COUNT;
        node_d = '{default: '0};
        for (int k = 0; k < COUNT; k++) begin
            src[k].mn = bus.inp[k*WIDTH +: WIDTH];
            src[k].idx = ADDR_WIDTH'(k);
            src[k].sec = '1;
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int n = 0; n < HALF; n++)
                node_d[l][n] = 2*n + 1 < cnt ? merge(src[2*n], src[2*n + 1 < COUNT ? 2*n + 1 : COUNT - 1])
                             : 2*n < cnt ? src[2*n] : '0;
            for (int k = 0; k < HALF; k++)
                src[k] = node_q[l][k];
            cnt = (cnt + 1) / 2;
        end
        vld_d = LEVELS'({vld_q, bus.in_valid});
        uniq_d = {1'b0, node_d[LEVELS-1][0].mn} + {1'b0, MARGIN} < {1'b0, node_d[LEVELS-1][0].sec};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            node_q <= '{default: '0};
            vld_q <= '0;
            uniq_q <= 1'b0;
        end else begin
            node_q <= node_d;
            vld_q <= vld_d;
            uniq_q <= uniq_d;
        end
    end

    assign bus.out_valid = vld_q[LEVELS-1];
    assign bus.outp = node_q[LEVELS-1][0].mn;
    assign bus.outp_addr = node_q[LEVELS-1][0].idx;
    assign bus.outp_second = node_q[LEVELS-1][0].sec;
    assign bus.outp_unique = uniq_q;
endmodule

// File: tb/tb_argmin_pipe.sv
// tb_argmin_pipe: directed and random checks of four argmin_pipe configurations against a reference model.
module tb_argmin_pipe;
    typedef struct packed {
        logic        v;
        logic [31:0] mn;
        logic [4:0]  idx;
        logic [31:0] sec;
        logic        u;
    } res_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic [31:0] c0 [17];
    logic [31:0] c1 [17];
    logic [31:0] c2 [17];
    logic [31:0] c3 [17];
    res_t        o0, o1, o2, o3;
    res_t        q0 [$];
    res_t        q1 [$];
    res_t        q2 [$];
    res_t        q3 [$];
    res_t        e;
    int          tests = 0;
    int          fails = 0;
    bit          live;

    always #5 clk = ~clk;

    argmin_pipe_if #(.WIDTH(32), .COUNT(10), .ADDR_WIDTH(4)) i0 ();
    argmin_pipe_if #(.WIDTH(32), .COUNT(10), .ADDR_WIDTH(4)) i1 ();
    argmin_pipe_if #(.WIDTH(32), .COUNT(3), .ADDR_WIDTH(2)) i2 ();
    argmin_pipe_if #(.WIDTH(32), .COUNT(17), .ADDR_WIDTH(5)) i3 ();

    argmin_pipe #(.WIDTH(32), .COUNT(10), .ADDR_WIDTH(4)) d0 (.clk(clk), .rst(rst), .bus(i0));
    argmin_pipe #(.WIDTH(32), .COUNT(10), .ADDR_WIDTH(4), .TIE_HIGH(1'b1), .MARGIN(32'd3)) d1 (.clk(clk), .rst(rst), .bus(i1));
    argmin_pipe #(.WIDTH(32), .COUNT(3), .ADDR_WIDTH(2)) d2 (.clk(clk), .rst(rst), .bus(i2));
    argmin_pipe #(.WIDTH(32), .COUNT(17), .ADDR_WIDTH(5)) d3 (.clk(clk), .rst(rst), .bus(i3));

    for (genvar g = 0; g < 10; g++) begin : g_in10
        assign i0.inp[g*32 +: 32] = c0[g];
        assign i1.inp[g*32 +: 32] = c1[g];
    end
    for (genvar g = 0; g < 3; g++) begin : g_in3
        assign i2.inp[g*32 +: 32] = c2[g];
    end
    for (genvar g = 0; g < 17; g++) begin : g_in17
        assign i3.inp[g*32 +: 32] = c3[g];
    end
    assign i0.in_valid = v0;
    assign i1.in_valid = v1;
    assign i2.in_valid = v2;
    assign i3.in_valid = v3;
    assign o0 = {i0.out_valid, i0.outp, 5'(i0.outp_addr), i0.outp_second, i0.outp_unique};
    assign o1 = {i1.out_valid, i1.outp, 5'(i1.outp_addr), i1.outp_second, i1.outp_unique};
    assign o2 = {i2.out_valid, i2.outp, 5'(i2.outp_addr), i2.outp_second, i2.outp_unique};
    assign o3 = {i3.out_valid, i3.outp, 5'(i3.outp_addr), i3.outp_second, i3.outp_unique};

    // Reference: linear scan for the chosen minimum, then the smallest of everything else.
    function automatic res_t model(input logic [31:0] c [17], input int n, input bit tie, input logic [31:0] m, input bit v);
        res_t r;
        int   best = 0;
        for (int i = 1; i < n; i++)
            if (c[i] < c[best] || (tie && c[i] == c[best])) best = i;
        r.v = v;
        r.mn = c[best];
        r.idx = 5'(best);
        r.sec = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            if (i != best && c[i] < r.sec) r.sec = c[i];
        r.u = ({1'b0, r.mn} + {1'b0, m}) < {1'b0, r.sec};
        return r;
    endfunction

    function automatic res_t exp_r(bit v, logic [31:0] mn, int idx, logic [31:0] sec, bit u);
        return {v, mn, 5'(idx), sec, u};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(string tag, res_t got, res_t exp);
        chk({tag, ".valid"}, 80'(got.v), 80'(exp.v));
        if (exp.v) begin
            chk({tag, ".outp"}, 80'(got.mn), 80'(exp.mn));
            chk({tag, ".addr"}, 80'(got.idx), 80'(exp.idx));
            chk({tag, ".second"}, 80'(got.sec), 80'(exp.sec));
            chk({tag, ".unique"}, 80'(got.u), 80'(exp.u));
        end
    endtask

    function automatic logic [31:0] rnd(int c);
        return c % 2 == 1 ? 32'($urandom) : 32'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 17; i++) begin
            c0[i] = '0;
            c1[i] = '0;
            c2[i] = '0;
            c3[i] = '0;
        end
        step(2);
        chk("reset0", 80'(o0), 80'(0));
        chk("reset1", 80'(o1), 80'(0));
        chk("reset2", 80'(o2), 80'(0));
        chk("reset3", 80'(o3), 80'(0));
        rst = 1'b0;
        step();
        for (int i = 0; i < 10; i++) c0[i] = 32'(9 - i);
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        step(2);
        cmp("descend_early", o0, exp_r(0, 0, 0, 0, 0));
        step();
        cmp("descend", o0, exp_r(1, 0, 9, 1, 1));
        step();
        cmp("descend_single", o0, exp_r(0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            c0[i] = (i == 2 || i == 7) ? 32'd5 : 32'd20;
            c1[i] = c0[i];
        end
        v0 = 1'b1;
        v1 = 1'b1;
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        step(3);
        cmp("tie_low", o0, exp_r(1, 5, 2, 5, 0));
        cmp("tie_high", o1, exp_r(1, 5, 7, 5, 0));
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++)
                c1[i] = k == 2 ? 32'hFFFF_FFFF : i == 4 ? 32'd10 : k == 0 ? 32'd13 : 32'd14;
            v1 = 1'b1;
            step();
            v1 = 1'b0;
            step(3);
            e = k == 0 ? exp_r(1, 10, 4, 13, 0) : k == 1 ? exp_r(1, 10, 4, 14, 1) : exp_r(1, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFF, 0);
            cmp($sformatf("margin%0d", k), o1, e);
        end
        step(2);
        for (int c = 0; c < 26; c++) begin
            live = c < 20 && c != 5 && c != 11;
            for (int i = 0; i < 17; i++) begin
                c0[i] = rnd(c);
                c1[i] = rnd(c);
                c2[i] = rnd(c);
                c3[i] = rnd(c);
            end
            v0 = live;
            v1 = live;
            v2 = live;
            v3 = live;
            q0.push_back(model(c0, 10, 1'b0, 32'd0, live));
            q1.push_back(model(c1, 10, 1'b1, 32'd3, live));
            q2.push_back(model(c2, 3, 1'b0, 32'd0, live));
            q3.push_back(model(c3, 17, 1'b0, 32'd0, live));
            step();
            if (q0.size() == 4) cmp("stream0", o0, q0.pop_front());
            if (q1.size() == 4) cmp("stream1", o1, q1.pop_front());
            if (q2.size() == 2) cmp("stream2", o2, q2.pop_front());
            if (q3.size() == 5) cmp("stream3", o3, q3.pop_front());
        end
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        v3 = 1'b0;
        step(6);
        for (int i = 0; i < 10; i++) c0[i] = 32'($urandom);
        v0 = 1'b1;
        step();
        for (int i = 0; i < 10; i++) c0[i] = 32'($urandom);
        step();
        rst = 1'b1;
        step();
        chk("midreset_clear", 80'(o0), 80'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) c0[i] = rnd(1);
        e = model(c0, 10, 1'b0, 32'd0, 1'b1);
        step();
        v0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("midreset_quiet%0d", k), o0, exp_r(0, 0, 0, 0, 0));
            step();
        end
        cmp("after_reset", o0, e);
        step();
        cmp("after_reset_single", o0, exp_r(0, 0, 0, 0, 0));
        c2[0] = 32'd50;
        c2[1] = 32'd40;
        c2[2] = 32'd7;
        for (int i = 0; i < 16; i++) c3[i] = 32'(1000 + 3 * i);
        c3[16] = 32'd5;
        v2 = 1'b1;
        v3 = 1'b1;
        step();
        v2 = 1'b0;
        v3 = 1'b0;
        cmp("count3_early", o2, exp_r(0, 0, 0, 0, 0));
        step();
        cmp("count3", o2, exp_r(1, 7, 2, 40, 1));
        step(2);
        cmp("count17_early", o3, exp_r(0, 0, 0, 0, 0));
        step();
        cmp("count17", o3, exp_r(1, 5, 16, 1000, 1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
